if_stage: RTL and testbench

- Instruction-fetch stage of the simple MIPS core. Sits directly upstream of the decode/register-file stage.
- Owns the PC register and next-PC selection (sequential, branch, jump, jr).
- Drives a req/ack instruction-memory port.
- Presents the fetched instr, pc and pc_add4 to decode. Holds them until decode signals accept.

---
 rtl/if_stage.sv | 126 ++++++++++++
 tb/tb_if_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one req/ack fetch at a time,
// holds the fetched instruction for decode until it is accepted, and then
// selects the next PC from the sequential, branch, jump or jr target.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_add4,
  output logic        instr_valid,
  input  logic        accept,
  input  logic [1:0]  npc_sel,
  input  logic        br_cond,
  input  logic [31:0] rdata1,
  output logic        fault
);

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_add4_reg, pc_add4_next;
  logic [31:0] instr_reg, instr_next;

  logic [31:0] br_offset;
  logic [31:0] target_pc;
  logic        jr_misaligned;

  // Outputs are decoded straight from the state so a reset drops the request
  // in the same instant, without waiting for a clock edge.
  assign imem_req    = (state_reg == ST_FETCH);
  assign instr_valid = (state_reg == ST_HOLD);
  assign fault       = (state_reg == ST_FAULT);
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign pc_add4     = pc_add4_reg;
  assign instr       = instr_reg;

  // Next-PC target from the held instruction; all arithmetic wraps at 32 bits.
  always_comb begin
    br_offset     = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    target_pc     = pc_add4_reg;
    jr_misaligned = 1'b0;
    case (npc_sel)
      NPC_SEQ: target_pc = pc_add4_reg;
      NPC_BR:  target_pc = br_cond ? (pc_add4_reg + br_offset) : pc_add4_reg;
      NPC_J:   target_pc = {pc_add4_reg[31:28], instr_reg[25:0], 2'b00};
      NPC_JR: begin
        target_pc     = rdata1;
        jr_misaligned = (rdata1[1:0] != 2'b00);
      end
      default: target_pc = pc_add4_reg;
    endcase
  end

  // Fetch sequencing: idle after reset, fetch with arbitrary wait states,
  // hold until decode accepts, or park in the fault state on a bad jr.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    pc_add4_next = pc_add4_reg;
    instr_next   = instr_reg;
    case (state_reg)
      ST_IDLE: begin
        // Any ack seen here belongs to a request killed by reset.
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (jr_misaligned) begin
            // pc keeps pointing at the offending jr for post-mortem.
            state_next = ST_FAULT;
          end else begin
            pc_next      = target_pc;
            pc_add4_next = target_pc + 32'd4;
            state_next   = ST_FETCH;
          end
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset to the boot PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= RESET_PC;
      pc_add4_reg <= RESET_PC + 32'd4;
      instr_reg   <= 32'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      pc_add4_reg <= pc_add4_next;
      instr_reg   <= instr_next;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scoreboard of fetched instructions plus a
// table of next-PC vectors and hand-written multi-cycle sequences.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [1:0]  SEL_SEQ  = 2'd0;
  localparam logic [1:0]  SEL_BR   = 2'd1;
  localparam logic [1:0]  SEL_J    = 2'd2;
  localparam logic [1:0]  SEL_JR   = 2'd3;
  localparam logic [31:0] JR_INSTR = 32'h03E0_0008;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_add4;
  logic        instr_valid;
  logic        accept;
  logic [1:0]  npc_sel;
  logic        br_cond;
  logic [31:0] rdata1;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_add4;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] instr;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] rdata1;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .pc_add4     (pc_add4),
    .instr_valid (instr_valid),
    .accept      (accept),
    .npc_sel     (npc_sel),
    .br_cond     (br_cond),
    .rdata1      (rdata1),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some wait escapes its bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    accept   = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_fault", 32'(fault),       32'd0);
    chk("rst_pc",    pc,               RESET_PC);
    chk("rst_add4",  pc_add4,          RESET_PC + 32'd4);
    chk("rst_instr", instr,            32'd0);
    chk("rst_addr",  imem_addr,        RESET_PC);
    tick();
    rst = 1'b0;
  endtask

  // Wait for the DUT to present an instruction, then compare it to the
  // oldest scoreboard entry.
  task automatic pop_check();
    exp_t e;
    for (int i = 0; i < 5 && !instr_valid; i++) tick();
    n_checks++;
    if (!instr_valid) begin
      n_errors++;
      $display("FAIL valid_arrives: got instr_valid=0, expected 1 within 5 cycles");
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_empty: got output with empty scoreboard, expected an entry");
    end else begin
      e = sb_q.pop_front();
      chk("sb_instr", instr,   e.instr);
      chk("sb_pc",    pc,      e.pc);
      chk("sb_add4",  pc_add4, e.pc_add4);
      $display("fetched pc=%h instr=%h", pc, instr);
    end
  endtask

  // Serve one fetch at exp_pc after the given number of wait states.
  task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] data, input int waits);
    exp_t e;
    for (int i = 0; i < 10 && !imem_req; i++) tick();
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("wait_req",  32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
    end
    e.pc      = exp_pc;
    e.pc_add4 = exp_pc + 32'd4;
    e.instr   = data;
    sb_q.push_back(e);
    imem_rdata = data;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    pop_check();
  endtask

  task automatic retire(input logic [1:0] sel, input logic br, input logic [31:0] r1);
    accept  = 1'b1;
    npc_sel = sel;
    br_cond = br;
    rdata1  = r1;
    tick();
    accept  = 1'b0;
    npc_sel = 2'($urandom);
    br_cond = 1'($urandom);
    rdata1  = $urandom;
  endtask

  initial begin
    logic [31:0] exp_add4;

    // start_pc, instr, sel, br, rdata1, exp_pc, exp_fault
    vec[0]  = '{32'h0000_3000, 32'h2408_0001, SEL_SEQ, 1'b0, 32'h0,         32'h0000_3004, 1'b0};
    vec[1]  = '{32'h0000_3000, 32'h1000_FFFF, SEL_BR,  1'b1, 32'h0,         32'h0000_3000, 1'b0};
    vec[2]  = '{32'h0000_3000, 32'h1000_FFFF, SEL_BR,  1'b0, 32'h0,         32'h0000_3004, 1'b0};
    vec[3]  = '{32'h0000_3004, 32'h0800_0C10, SEL_J,   1'b0, 32'h0,         32'h0000_3040, 1'b0};
    vec[4]  = '{32'h0000_3000, JR_INSTR,      SEL_JR,  1'b0, 32'h0000_3100, 32'h0000_3100, 1'b0};
    vec[5]  = '{32'h0000_3000, JR_INSTR,      SEL_JR,  1'b0, 32'h0000_3102, 32'h0000_3000, 1'b1};
    vec[6]  = '{32'hFFFF_FFFC, 32'h0000_0000, SEL_SEQ, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vec[7]  = '{32'h0000_3000, 32'h1000_0010, SEL_BR,  1'b1, 32'h0,         32'h0000_3044, 1'b0};
    vec[8]  = '{32'hF000_0000, 32'h0800_0010, SEL_J,   1'b0, 32'h0,         32'hF000_0040, 1'b0};
    vec[9]  = '{32'h0000_3000, JR_INSTR,      SEL_JR,  1'b0, 32'h0000_3101, 32'h0000_3000, 1'b1};
    vec[10] = '{32'h0000_3000, 32'h1000_FFFF, SEL_SEQ, 1'b1, 32'h0,         32'h0000_3004, 1'b0};

    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    accept     = 1'b0;
    npc_sel    = SEL_SEQ;
    br_cond    = 1'b0;
    rdata1     = 32'd0;

    // Latency: ack already high at reset release; IDLE must ignore it.
    tick();
    tick();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h2408_0001;
    sb_q.push_back('{RESET_PC, RESET_PC + 32'd4, 32'h2408_0001});
    tick();
    chk("lat_edge1_valid", 32'(instr_valid), 32'd0);
    chk("lat_edge1_req",   32'(imem_req),    32'd1);
    chk("lat_edge1_addr",  imem_addr,        RESET_PC);
    tick();
    imem_ack = 1'b0;
    chk("lat_edge2_valid", 32'(instr_valid), 32'd1);
    pop_check();

    // Hold: stray acks ignored, everything frozen while accept=0.
    for (int i = 0; i < 4; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      tick();
      chk("hold_req",   32'(imem_req),    32'd0);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr,            32'h2408_0001);
      chk("hold_pc",    pc,               RESET_PC);
    end
    imem_ack = 1'b0;
    retire(SEL_SEQ, 1'b0, 32'd0);
    // Three wait states; accept while not valid must not move the PC.
    for (int i = 0; i < 3; i++) begin
      chk("ws_req",  32'(imem_req), 32'd1);
      chk("ws_addr", imem_addr,     32'h0000_3004);
      accept  = 1'b1;
      npc_sel = SEL_JR;
      rdata1  = 32'h0000_5000;
      tick();
    end
    accept = 1'b0;
    fetch(32'h0000_3004, 32'h2409_0002, 0);
    $display("hold/wait-state sequence done pc=%h", pc);

    // Table of next-PC selections.
    for (int v = 0; v < NV; v++) begin
      do_reset();
      if (vec[v].start_pc != RESET_PC) begin
        fetch(RESET_PC, JR_INSTR, 0);
        retire(SEL_JR, 1'b0, vec[v].start_pc);
      end
      fetch(vec[v].start_pc, vec[v].instr, v % 3);
      retire(vec[v].sel, vec[v].br, vec[v].rdata1);
      exp_add4 = vec[v].exp_fault ? vec[v].start_pc + 32'd4 : vec[v].exp_pc + 32'd4;
      chk("vec_pc",    pc,               vec[v].exp_pc);
      chk("vec_add4",  pc_add4,          exp_add4);
      chk("vec_addr",  imem_addr,        vec[v].exp_pc);
      chk("vec_fault", 32'(fault),       32'(vec[v].exp_fault));
      chk("vec_req",   32'(imem_req),    32'(!vec[v].exp_fault));
      chk("vec_valid", 32'(instr_valid), 32'd0);
      if (vec[v].exp_fault) begin
        // Fault is sticky; further accepts and acks change nothing.
        for (int i = 0; i < 3; i++) begin
          imem_ack = 1'b1;
          retire(SEL_SEQ, 1'b0, 32'd0);
          chk("flt_fault", 32'(fault),       32'd1);
          chk("flt_req",   32'(imem_req),    32'd0);
          chk("flt_valid", 32'(instr_valid), 32'd0);
          chk("flt_pc",    pc,               vec[v].start_pc);
        end
        imem_ack = 1'b0;
      end else begin
        fetch(vec[v].exp_pc, 32'hA5A5_0000 | 32'(v), 0);
      end
      $display("vec %0d start=%h sel=%0d br=%0d -> pc=%h fault=%0d",
               v, vec[v].start_pc, vec[v].sel, vec[v].br, pc, fault);
    end

    // Reset during a fetch wait; the late ack lands in IDLE.
    do_reset();
    for (int i = 0; i < 10 && !imem_req; i++) tick();
    tick();
    chk("mid_req_before", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_req_drop", 32'(imem_req), 32'd0);
    tick();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_req",   32'(imem_req),    32'd1);
    chk("late_ack_addr",  imem_addr,        RESET_PC);
    fetch(RESET_PC, 32'h240A_0003, 1);
    $display("reset-mid-fetch sequence done instr=%h", instr);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
